// File: rtl/reservoir_history_ctrl_pkg.sv
// Shared types and default widths for the reservoir history RAM controller.
package reservoir_hist_pkg;

   localparam int ADDR_WIDTH_DEF   = 20;
   localparam int DATA_WIDTH_DEF   = 32;
   localparam int MAX_WR_BURST_DEF = 8;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } fill_state_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } grant_e;

endpackage

// File: rtl/reservoir_history_ctrl_arbiter.sv
// Burst-limited grant between the sample writer and the readout reader.
// The writer normally wins, but a waiting reader is let through after MAX_WR_BURST writes.
module hist_rr_arbiter
   import reservoir_hist_pkg::*;
#(
   parameter int MAX_WR_BURST = MAX_WR_BURST_DEF
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   wr_valid,
   input  logic   rd_valid,
   input  logic   wr_block,
   input  logic   clear,
   output grant_e grant
);

   localparam int            BW          = $clog2(MAX_WR_BURST + 1);
   localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_WR_BURST);

   logic [BW-1:0] burst_cnt_q;
   logic [BW-1:0] burst_cnt_d;
   logic          wr_req;

   always_comb begin
      wr_req = wr_valid && !wr_block;
      grant  = NONE;
      if (clear) begin
         grant = NONE;
      end else if (wr_req && rd_valid) begin
         grant = (burst_cnt_q == BURST_LIMIT) ? RD : WR;
      end else if (wr_req) begin
         grant = WR;
      end else if (rd_valid) begin
         grant = RD;
      end
   end

   // The count only measures writes that overtook a reader that is still waiting.
   always_comb begin
      burst_cnt_d = burst_cnt_q;
      if (clear || !rd_valid || grant == RD) begin
         burst_cnt_d = '0;
      end else if (grant == WR) begin
         burst_cnt_d = burst_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_cnt_q <= '0;
      end else begin
         burst_cnt_q <= burst_cnt_d;
      end
   end

endmodule

// File: rtl/reservoir_history_ctrl.sv
// Sequences the single-port reservoir history RAM between the sample writer and the readout reader.
// Writes fill addresses 0..MEM_SIZE-1 in order; reads return data or an error two cycles after accept.
module reservoir_history_ctrl
   import reservoir_hist_pkg::*;
#(
   parameter int MEM_SIZE     = 2**ADDR_WIDTH_DEF,
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int MAX_WR_BURST = MAX_WR_BURST_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_data_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_err,
   output logic [ADDR_WIDTH:0]   wr_count,
   output logic                  full,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(MEM_SIZE);

   fill_state_e           state_q, state_d;
   logic [ADDR_WIDTH:0]   wr_count_q, wr_count_d;
   logic                  full_q, full_d;
   logic                  mem_wen_q, mem_wen_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
   logic                  rd_s1_vld_q, rd_s1_vld_d;
   logic                  rd_s1_err_q, rd_s1_err_d;
   logic                  rd_s2_vld_q, rd_s2_vld_d;
   logic                  rd_s2_err_q, rd_s2_err_d;
   logic                  rd_data_valid_q, rd_data_valid_d;
   logic                  rd_err_q, rd_err_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

   grant_e                grant;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  rd_in_range;

   hist_rr_arbiter #(
      .MAX_WR_BURST (MAX_WR_BURST)
   ) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (wr_valid),
      .rd_valid (rd_valid),
      .wr_block (state_q == FULL),
      .clear    (clear),
      .grant    (grant)
   );

   // Handshakes stay low while reset is held, even though the arbiter itself is combinational.
   assign wr_ready    = rst_n && !clear && (state_q != FULL) && (grant == WR);
   assign rd_ready    = rst_n && !clear && (grant == RD);
   assign wr_acc      = wr_valid && wr_ready;
   assign rd_acc      = rd_valid && rd_ready;
   assign rd_in_range = ({1'b0, rd_addr} < wr_count_q);

   always_comb begin
      state_d         = state_q;
      wr_count_d      = wr_count_q;
      mem_wen_d       = 1'b0;
      mem_addr_d      = mem_addr_q;
      mem_din_d       = mem_din_q;
      rd_s1_vld_d     = rd_acc;
      rd_s1_err_d     = rd_acc && !rd_in_range;
      rd_s2_vld_d     = rd_s1_vld_q;
      rd_s2_err_d     = rd_s1_err_q;
      rd_data_valid_d = rd_s2_vld_q;
      rd_err_d        = rd_s2_vld_q && rd_s2_err_q;
      rd_data_d       = (rd_s2_vld_q && !rd_s2_err_q) ? mem_dout : '0;

      // An out-of-range read leaves the RAM address untouched so it never toggles the RAM.
      if (wr_acc) begin
         mem_wen_d  = 1'b1;
         mem_addr_d = wr_count_q[ADDR_WIDTH-1:0];
         mem_din_d  = wr_data;
         wr_count_d = wr_count_q + 1'b1;
      end else if (rd_acc && rd_in_range) begin
         mem_addr_d = rd_addr;
      end

      case (state_q)
         EMPTY: begin
            if (wr_acc) begin
               state_d = (wr_count_d == FULL_COUNT) ? FULL : FILLING;
            end
         end
         FILLING: begin
            if (wr_acc && (wr_count_d == FULL_COUNT)) begin
               state_d = FULL;
            end
         end
         FULL: begin
            state_d = FULL;
         end
         default: begin
            state_d = EMPTY;
         end
      endcase

      if (clear) begin
         state_d    = EMPTY;
         wr_count_d = '0;
      end

      full_d = (wr_count_d == FULL_COUNT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= EMPTY;
         wr_count_q      <= '0;
         full_q          <= 1'b0;
         mem_wen_q       <= 1'b0;
         mem_addr_q      <= '0;
         mem_din_q       <= '0;
         rd_s1_vld_q     <= 1'b0;
         rd_s1_err_q     <= 1'b0;
         rd_s2_vld_q     <= 1'b0;
         rd_s2_err_q     <= 1'b0;
         rd_data_valid_q <= 1'b0;
         rd_err_q        <= 1'b0;
         rd_data_q       <= '0;
      end else begin
         state_q         <= state_d;
         wr_count_q      <= wr_count_d;
         full_q          <= full_d;
         mem_wen_q       <= mem_wen_d;
         mem_addr_q      <= mem_addr_d;
         mem_din_q       <= mem_din_d;
         rd_s1_vld_q     <= rd_s1_vld_d;
         rd_s1_err_q     <= rd_s1_err_d;
         rd_s2_vld_q     <= rd_s2_vld_d;
         rd_s2_err_q     <= rd_s2_err_d;
         rd_data_valid_q <= rd_data_valid_d;
         rd_err_q        <= rd_err_d;
         rd_data_q       <= rd_data_d;
      end
   end

   assign wr_count      = wr_count_q;
   assign full          = full_q;
   assign mem_wen       = mem_wen_q;
   assign mem_addr      = mem_addr_q;
   assign mem_din       = mem_din_q;
   assign rd_data_valid = rd_data_valid_q;
   assign rd_err        = rd_err_q;
   assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_reservoir_history_ctrl.sv
// Bench for reservoir_history_ctrl on a 16-word RAM: directed vector table, corner sequences,
// then random traffic checked against a transaction-level model of fill level, grants and responses.
module tb_reservoir_history_ctrl;

   localparam int AW   = 4;
   localparam int MS   = 16;
   localparam int DW   = 32;
   localparam int MAXB = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic          wr_valid;
   logic          wr_ready;
   logic [DW-1:0] wr_data;
   logic          rd_valid;
   logic          rd_ready;
   logic [AW-1:0] rd_addr;
   logic          rd_data_valid;
   logic [DW-1:0] rd_data;
   logic          rd_err;
   logic [AW:0]   wr_count;
   logic          full;
   logic          mem_wen;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   logic [DW-1:0] ram [MS];

   always #5 clk = ~clk;

   reservoir_history_ctrl #(
      .MEM_SIZE     (MS),
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .MAX_WR_BURST (MAXB)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (clear),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_data       (wr_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_addr       (rd_addr),
      .rd_data_valid (rd_data_valid),
      .rd_data       (rd_data),
      .rd_err        (rd_err),
      .wr_count      (wr_count),
      .full          (full),
      .mem_wen       (mem_wen),
      .mem_addr      (mem_addr),
      .mem_din       (mem_din),
      .mem_dout      (mem_dout)
   );

   // Single-port RAM with registered read, as the controller expects to drive it.
   always @(posedge clk) begin
      if (mem_wen) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int            m_count;
   int            m_streak;
   logic [DW-1:0] m_mem [MS];
   logic          m_wen;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_din;

   typedef struct {
      int            due;
      logic          err;
      logic [DW-1:0] data;
   } resp_t;
   resp_t pend [$];

   logic last_wr_ready;
   logic last_rd_ready;

   typedef struct {
      logic          w;
      logic          r;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          c;
      logic          exp_wr;
      logic          exp_rd;
   } vec_t;
   vec_t vecs [13];

   function automatic vec_t mk(input logic w, input logic r, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic c,
                               input logic ew, input logic er);
      vec_t v;
      v.w = w; v.r = r; v.a = a; v.d = d; v.c = c; v.exp_wr = ew; v.exp_rd = er;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic modelReset();
      m_count  = 0;
      m_streak = 0;
      m_wen    = 1'b0;
      m_addr   = '0;
      m_din    = '0;
      pend.delete();
   endtask

   // Drives one cycle, checks the handshakes, and advances the model by one accepted operation.
   task automatic applyStimulus(input logic w, input logic r, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic c);
      logic  w_ok, gw, gr, in_range;
      resp_t rsp;
      wr_valid = w;
      rd_valid = r;
      rd_addr  = a;
      wr_data  = d;
      clear    = c;
      #1;
      w_ok = w && (m_count < MS);
      gw   = 1'b0;
      gr   = 1'b0;
      if (!c) begin
         if (w_ok && r) begin
            if (m_streak == MAXB) gr = 1'b1;
            else                  gw = 1'b1;
         end else if (w_ok) begin
            gw = 1'b1;
         end else if (r) begin
            gr = 1'b1;
         end
      end
      check("wr_ready", {63'd0, wr_ready}, {63'd0, gw});
      check("rd_ready", {63'd0, rd_ready}, {63'd0, gr});
      last_wr_ready = wr_ready;
      last_rd_ready = rd_ready;

      if (c || !r || gr) m_streak = 0;
      else if (gw)       m_streak++;
      m_wen    = gw;
      in_range = (int'(a) < m_count);
      if (gw) begin
         m_addr           = AW'(m_count);
         m_din            = d;
         m_mem[m_count]   = d;
         m_count++;
      end
      if (gr) begin
         if (in_range) m_addr = a;
         rsp.due  = cyc + 2;
         rsp.err  = !in_range;
         rsp.data = in_range ? m_mem[a] : {DW{1'b0}};
         pend.push_back(rsp);
      end
      if (c) m_count = 0;
      @(negedge clk);
      cyc++;
   endtask

   // Compares the registered outputs produced by the edge that just passed.
   task automatic checkOutput();
      logic          exp_v, exp_e;
      logic [DW-1:0] exp_d;
      exp_v = 1'b0;
      exp_e = 1'b0;
      exp_d = '0;
      if (pend.size() > 0 && pend[0].due == cyc - 1) begin
         exp_v = 1'b1;
         exp_e = pend[0].err;
         exp_d = pend[0].data;
         void'(pend.pop_front());
      end
      check("rd_data_valid", {63'd0, rd_data_valid}, {63'd0, exp_v});
      if (exp_v) begin
         check("rd_err", {63'd0, rd_err}, {63'd0, exp_e});
         check("rd_data", {32'd0, rd_data}, {32'd0, exp_d});
      end
      check("mem_wen", {63'd0, mem_wen}, {63'd0, m_wen});
      check("mem_addr", {60'd0, mem_addr}, {60'd0, m_addr});
      check("mem_din", {32'd0, mem_din}, {32'd0, m_din});
      check("wr_count", {59'd0, wr_count}, 64'(m_count));
      check("full", {63'd0, full}, {63'd0, (m_count == MS)});
   endtask

   task automatic step(input logic w, input logic r, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic c);
      applyStimulus(w, r, a, d, c);
      checkOutput();
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_wr_ready"}, {63'd0, wr_ready}, 64'd0);
      check({tag, "_rd_ready"}, {63'd0, rd_ready}, 64'd0);
      check({tag, "_rd_data_valid"}, {63'd0, rd_data_valid}, 64'd0);
      check({tag, "_mem_wen"}, {63'd0, mem_wen}, 64'd0);
      check({tag, "_mem_addr"}, {60'd0, mem_addr}, 64'd0);
      check({tag, "_wr_count"}, {59'd0, wr_count}, 64'd0);
      check({tag, "_full"}, {63'd0, full}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [19:0] pattern;

      rst_n    = 1'b0;
      clear    = 1'b0;
      wr_valid = 1'b1;
      rd_valid = 1'b1;
      rd_addr  = '0;
      wr_data  = '0;
      modelReset();
      repeat (2) @(negedge clk);
      #1;
      checkAllZero("reset");
      wr_valid = 1'b0;
      rd_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      vecs[0]  = mk(1'b1, 1'b0, 4'd0, 32'hA0, 1'b0, 1'b1, 1'b0);
      vecs[1]  = mk(1'b1, 1'b0, 4'd0, 32'hA1, 1'b0, 1'b1, 1'b0);
      vecs[2]  = mk(1'b1, 1'b0, 4'd0, 32'hA2, 1'b0, 1'b1, 1'b0);
      vecs[3]  = mk(1'b1, 1'b0, 4'd0, 32'hA3, 1'b0, 1'b1, 1'b0);
      vecs[4]  = mk(1'b0, 1'b1, 4'd2, 32'h00, 1'b0, 1'b0, 1'b1);
      vecs[5]  = mk(1'b0, 1'b1, 4'd4, 32'h00, 1'b0, 1'b0, 1'b1);
      vecs[6]  = mk(1'b0, 1'b0, 4'd0, 32'h00, 1'b0, 1'b0, 1'b0);
      vecs[7]  = mk(1'b0, 1'b0, 4'd0, 32'h00, 1'b0, 1'b0, 1'b0);
      vecs[8]  = mk(1'b1, 1'b1, 4'd1, 32'hC4, 1'b0, 1'b1, 1'b0);
      vecs[9]  = mk(1'b0, 1'b1, 4'd4, 32'h00, 1'b0, 1'b0, 1'b1);
      vecs[10] = mk(1'b1, 1'b1, 4'd0, 32'hD0, 1'b1, 1'b0, 1'b0);
      vecs[11] = mk(1'b1, 1'b0, 4'd0, 32'hB0, 1'b0, 1'b1, 1'b0);
      vecs[12] = mk(1'b0, 1'b0, 4'd0, 32'h00, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].c);
         check("tbl_wr_ready", {63'd0, last_wr_ready}, {63'd0, vecs[i].exp_wr});
         check("tbl_rd_ready", {63'd0, last_rd_ready}, {63'd0, vecs[i].exp_rd});
         checkOutput();
      end
      check("tbl_count_after_clear", {59'd0, wr_count}, 64'd1);

      // Writer and reader both always requesting: 8 writes, 1 read, 8 writes to full, then reads.
      step(1'b0, 1'b0, 4'd0, 32'h0, 1'b1);
      pattern = '0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 4'd0, 32'hC000_0000 | i, 1'b0);
         pattern[i] = last_wr_ready;
      end
      check("burst_pattern", {44'd0, pattern}, 64'h1FEFF);
      check("full_flag", {63'd0, full}, 64'd1);
      check("full_count", {59'd0, wr_count}, 64'd16);
      step(1'b1, 1'b0, 4'd0, 32'hDEAD, 1'b0);
      step(1'b1, 1'b1, 4'd15, 32'hBEEF, 1'b0);
      step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);

      // Clear with two reads in flight; both responses must still carry the old data.
      step(1'b0, 1'b1, 4'd3, 32'h0, 1'b0);
      step(1'b0, 1'b1, 4'd5, 32'h0, 1'b0);
      step(1'b1, 1'b1, 4'd0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 4'd0, 32'hE0, 1'b0);
      check("post_clear_addr", {60'd0, mem_addr}, 64'd0);
      check("post_clear_wen", {63'd0, mem_wen}, 64'd1);

      // Reset in the middle of traffic with a read response still in the pipeline.
      step(1'b1, 1'b1, 4'd0, 32'hE1, 1'b0);
      step(1'b0, 1'b1, 4'd0, 32'h0, 1'b0);
      step(1'b1, 1'b1, 4'd0, 32'hE2, 1'b0);
      wr_valid = 1'b1;
      rd_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      modelReset();
      @(negedge clk);
      @(negedge clk);
      wr_valid = 1'b0;
      rd_valid = 1'b0;
      rst_n    = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);

      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              AW'($urandom_range(0, MS - 1)), $urandom(), $urandom_range(0, 39) == 0);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
      check("pending_drained", 64'(pend.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
